stopwatch_scan_ctrl: RTL and testbench

//  mm:ss stopwatch controller that owns the minutes/seconds counters and time-shares ONE

---
 rtl/stopwatch_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_stopwatch_scan_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_scan_ctrl.sv
// mm:ss stopwatch controller. It owns the minutes/seconds counters and time-shares one
// external 0..59 two-digit 7-seg decoder between the seconds and minutes fields. It
// registers the decoder's segments together with a one-hot field strobe.
module stopwatch_scan_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic [5:0]  dec_number,
  input  logic [13:0] dec_segments,
  output logic [13:0] seg_out,
  output logic [1:0]  field_sel,
  output logic [5:0]  sec_val,
  output logic [5:0]  min_val,
  output logic        running,
  output logic        rollover
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [5:0]         MAX_VAL    = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef enum logic {
    FIELD_SEC = 1'b0,
    FIELD_MIN = 1'b1
  } field_t;

  state_t               r_state;
  logic                 r_running;
  logic [PRESC_W-1:0]   r_presc;
  logic [5:0]           r_sec;
  logic [5:0]           r_min;
  logic                 r_rollover;
  logic                 r_lap_hold;
  logic [5:0]           r_snap_sec;
  logic [5:0]           r_snap_min;
  logic [SCAN_W-1:0]    r_scan_cnt;
  field_t               r_field;
  logic [13:0]          r_seg_out;
  logic [1:0]           r_field_sel;

  logic                 w_tick;
  logic [5:0]           w_disp_sec;
  logic [5:0]           w_disp_min;

  // One-second tick: the last prescaler count of a running cycle. A clear in the same
  // cycle suppresses it so a cleared stopwatch never shows 00:01.
  assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST) && !clear;

  // Run-control FSM; clear beats stop, stop beats start.
  // NOTE: every register below uses <= so all blocks see the pre-edge values of each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else if (clear) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Sub-second prescaler: advances only while running and holds in PAUSE, so a resume
  // keeps the phase. It is zeroed by clear and in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (clear || (r_state == ST_IDLE)) begin
      r_presc <= '0;
    end else if (r_state == ST_RUN) begin
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PRESC_W'(1);
    end
  end

  // mm:ss counters with the 59:59 -> 00:00 wrap and a one-cycle rollover pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec      <= '0;
      r_min      <= '0;
      r_rollover <= 1'b0;
    end else begin
      // NOTE: the default assignment below turns r_rollover into a self-clearing pulse.
      r_rollover <= 1'b0;
      if (clear) begin
        r_sec <= '0;
        r_min <= '0;
      end else if (w_tick) begin
        if (r_sec == MAX_VAL) begin
          r_sec <= '0;
          if (r_min == MAX_VAL) begin
            r_min      <= '0;
            r_rollover <= 1'b1;
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end
    end
  end

  // Lap hold: the first lap freezes the displayed value and the second lap releases it.
  // The snapshot takes the pre-tick counter value because it samples the registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap_hold <= 1'b0;
      r_snap_sec <= '0;
      r_snap_min <= '0;
    end else if (clear) begin
      r_lap_hold <= 1'b0;
    end else if (lap) begin
      if (!r_lap_hold) begin
        r_snap_sec <= r_sec;
        r_snap_min <= r_min;
        r_lap_hold <= 1'b1;
      end else begin
        r_lap_hold <= 1'b0;
      end
    end
  end

  // Display scan: a free-running slot counter. The field flips at the end of each slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_field    <= FIELD_SEC;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_field    <= (r_field == FIELD_SEC) ? FIELD_MIN : FIELD_SEC;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Value presented to the shared decoder for the field currently scanned.
  assign w_disp_sec = r_lap_hold ? r_snap_sec : r_sec;
  assign w_disp_min = r_lap_hold ? r_snap_min : r_min;
  assign dec_number = (r_field == FIELD_SEC) ? w_disp_sec : w_disp_min;

  // Output stage: segments and strobe are captured on the same edge so they always match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_out   <= '0;
      r_field_sel <= 2'b00;
    end else begin
      r_seg_out   <= dec_segments;
      r_field_sel <= (r_field == FIELD_SEC) ? 2'b01 : 2'b10;
    end
  end

  assign seg_out   = r_seg_out;
  assign field_sel = r_field_sel;
  assign sec_val   = r_sec;
  assign min_val   = r_min;
  assign running   = r_running;
  assign rollover  = r_rollover;

endmodule

// File: tb/tb_stopwatch_scan_ctrl.sv
// Self-checking bench for stopwatch_scan_ctrl. The reference model tracks elapsed running
// cycles and derives mm:ss, the scanned field and the decoder contents arithmetically.
module tb_stopwatch_scan_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 3;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSE  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, clear, lap;
  logic [5:0]  dec_number;
  logic [13:0] dec_segments;
  logic [13:0] seg_out;
  logic [1:0]  field_sel;
  logic [5:0]  sec_val, min_val;
  logic        running, rollover;
  bit          force_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stopwatch_scan_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .lap         (lap),
    .dec_number  (dec_number),
    .dec_segments(dec_segments),
    .seg_out     (seg_out),
    .field_sel   (field_sel),
    .sec_val     (sec_val),
    .min_val     (min_val),
    .running     (running),
    .rollover    (rollover)
  );

  // External decoder model: abcdefg per digit, all-zero outside 0..59.
  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [13:0] decode(input int n);
    if (n < 0 || n > 59) return 14'd0;
    return {digit_seg(n / 10), digit_seg(n % 10)};
  endfunction

  always_comb dec_segments = force_zero ? 14'd0 : decode(int'(dec_number));

  // Reference model state.
  int          m_state;
  longint      m_run_cyc;   // running cycles since last clear/reset
  longint      m_cyc;       // clocks since reset release
  bit          m_hold;
  int          m_snap;
  bit          m_roll;
  logic [13:0] m_seg;
  logic [1:0]  m_fs;

  function automatic int m_total();
    return int'((m_run_cyc / TICK_DIV) % 3600);
  endfunction

  function automatic bit m_field_min();
    return ((m_cyc / SCAN_DIV) % 2) == 1;
  endfunction

  function automatic int m_disp();
    return m_hold ? m_snap : m_total();
  endfunction

  function automatic int m_num();
    return m_field_min() ? m_disp() / 60 : m_disp() % 60;
  endfunction

  task automatic model_reset();
    m_state   = M_IDLE;
    m_run_cyc = 0;
    m_cyc     = 0;
    m_hold    = 1'b0;
    m_snap    = 0;
    m_roll    = 1'b0;
    m_seg     = 14'd0;
    m_fs      = 2'b00;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl, input bit lp);
    int          pre_total;
    logic [13:0] seg_next;
    logic [1:0]  fs_next;
    bit          tick;
    pre_total = m_total();
    seg_next  = force_zero ? 14'd0 : decode(m_num());
    fs_next   = m_field_min() ? 2'b10 : 2'b01;
    tick      = 1'b0;
    m_roll    = 1'b0;
    if (cl) begin
      m_run_cyc = 0;
      m_hold    = 1'b0;
      m_state   = M_IDLE;
    end else begin
      if (lp) begin
        if (!m_hold) begin
          m_snap = pre_total;
          m_hold = 1'b1;
        end else begin
          m_hold = 1'b0;
        end
      end
      if (m_state == M_RUN) begin
        m_run_cyc++;
        tick = (m_run_cyc % TICK_DIV) == 0;
      end
      if (tick && m_total() == 0) m_roll = 1'b1;
      if (m_state == M_RUN && sp)      m_state = M_PAUSE;
      else if (m_state != M_RUN && st) m_state = M_RUN;
    end
    m_cyc++;
    m_seg = seg_next;
    m_fs  = fs_next;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("sec",       32'(sec_val),    32'(m_total() % 60));
    check("min",       32'(min_val),    32'(m_total() / 60));
    check("running",   32'(running),    32'(m_state == M_RUN));
    check("rollover",  32'(rollover),   32'(m_roll));
    check("dec_num",   32'(dec_number), 32'(m_num()));
    check("field_sel", 32'(field_sel),  32'(m_fs));
    check("seg_out",   32'(seg_out),    32'(m_seg));
  endtask

  // One clock: inputs are applied at the negedge, the model advances at the posedge,
  // and the outputs are compared at the following negedge.
  task automatic cycle(input bit st = 0, input bit sp = 0, input bit cl = 0, input bit lp = 0);
    start = st; stop = sp; clear = cl; lap = lp;
    @(posedge clk);
    model_step(st, sp, cl, lp);
    @(negedge clk);
    start = 0; stop = 0; clear = 0; lap = 0;
    check_all();
  endtask

  // Asynchronous reset asserted between edges; its effect must be immediate.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_sec",  32'(sec_val),   32'd0);
    check("rst_min",  32'(min_val),   32'd0);
    check("rst_run",  32'(running),   32'd0);
    check("rst_roll", 32'(rollover),  32'd0);
    check("rst_seg",  32'(seg_out),   32'd0);
    check("rst_fsel", 32'(field_sel), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  task automatic run_until(input int target, input int limit);
    for (int i = 0; i < limit && m_total() != target; i++) cycle();
    check("reach_sec", 32'(sec_val), 32'(target % 60));
    check("reach_min", 32'(min_val), 32'(target / 60));
  endtask

  task automatic wait_sec_slot();
    for (int i = 0; i < 2 * SCAN_DIV && m_field_min(); i++) cycle();
  endtask

  initial begin
    int pre;
    int roll_cnt;
    int r;
    reset = 1'b1; start = 0; stop = 0; clear = 0; lap = 0; force_zero = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Idle: counters stay zero, the scan strobe alternates.
    for (int i = 0; i < 20; i++) cycle();
    check("idle_running", 32'(running), 32'd0);

    // Start, one minute of ticks.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 60 * TICK_DIV; i++) cycle();
    check("minute_min", 32'(min_val), 32'd1);
    check("minute_sec", 32'(sec_val), 32'd0);

    // Two ticks, one more cycle, stop; resume 10 cycles later keeps phase.
    for (int i = 0; i < 2 * TICK_DIV; i++) cycle();
    cycle();
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle();
    check("pause_sec", 32'(sec_val), 32'd2);
    cycle(1, 0, 0, 0);
    cycle();
    check("phase_hold", 32'(sec_val), 32'd2);
    cycle();
    check("phase_tick", 32'(sec_val), 32'd3);

    // Count up to 59:58, then two more ticks wrap to 00:00 with one rollover pulse.
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    run_until(3598, 20000);
    roll_cnt = 0;
    for (int i = 1; i <= 2 * TICK_DIV + 2; i++) begin
      cycle();
      if (rollover) roll_cnt++;
      if (i == 2 * TICK_DIV) begin
        check("wrap_sec",  32'(sec_val),  32'd0);
        check("wrap_min",  32'(min_val),  32'd0);
        check("wrap_roll", 32'(rollover), 32'd1);
      end
    end
    check("roll_once", 32'(roll_cnt), 32'd1);

    // start+stop+clear together while running at 00:07.
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    run_until(7, 100);
    cycle(1, 1, 1, 0);
    check("ssc_running", 32'(running), 32'd0);
    check("ssc_sec",     32'(sec_val), 32'd0);
    check("ssc_min",     32'(min_val), 32'd0);

    // Decoder path: 37 in the seconds slot.
    cycle(1, 0, 0, 0);
    run_until(37, 400);
    cycle(0, 1, 0, 0);
    wait_sec_slot();
    check("dec37_num", 32'(dec_number), 32'd37);
    cycle();
    check("dec37_seg",  32'(seg_out),   32'(14'b1111001_1110000));
    check("dec37_fsel", 32'(field_sel), 32'd1);

    // Lap hold at 00:05, run to 00:08.
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    run_until(5, 100);
    cycle(0, 0, 0, 1);
    run_until(8, 100);
    cycle(0, 1, 0, 0);
    wait_sec_slot();
    check("lap_live",  32'(sec_val),    32'd8);
    check("lap_frozen", 32'(dec_number), 32'd5);
    cycle(0, 0, 0, 1);
    wait_sec_slot();
    check("lap_release", 32'(dec_number), 32'd8);

    // Lap on the same cycle as a tick latches the pre-tick value.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4 * TICK_DIV && !(m_state == M_RUN && (m_run_cyc + 1) % TICK_DIV == 0); i++)
      cycle();
    pre = m_total();
    cycle(0, 0, 0, 1);
    check("laptick_sec", 32'(sec_val), 32'((pre + 1) % 60));
    cycle(0, 1, 0, 0);
    wait_sec_slot();
    check("laptick_snap", 32'(dec_number), 32'(pre % 60));

    // Reset in the middle of operation.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle();
    do_reset();

    // Randomized pulses, decoder blanking and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 63));
      force_zero = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      else cycle(r < 6, r >= 6 && r < 8, r == 8, r >= 9 && r < 12);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
